debug_ring_arbiter: RTL and testbench
=====================================

// Module: debug_ring_arbiter
//
// PURPOSE
//   Packet-granular 2:1 arbiter for one debug-ring output link. Merges
//   ring-through traffic and local module injection onto a single
//   dii_flit stream. The link is locked per packet until the flit with
//   .last is accepted. Ring traffic has priority, but local injection is
//   guaranteed a slot after MAX_RING_BURST consecutive ring packets.
//   Sits between the upstream ring segment plus local port and the
//   downstream ring buffer of each debug_ring_expand hop.
//
// PARAMETERS
//   MAX_RING_BURST  2   ring packets granted back-to-back while local waits (>=1)
//   STAT_WIDTH      16  width of packet counters (DEBUG_RING_ARB_STATS_EN only)
//
// PORTS
//   clk             in   1           clock
//   rst             in   1           synchronous reset, active-low
//   ring_in         in   dii_flit    ring-through flit (valid, last, data[15:0])
//   ring_in_ready   out  1           ring_in accepted when valid & ready
//   local_in        in   dii_flit    local injection flit
//   local_in_ready  out  1           local_in accepted when valid & ready
//   out             out  dii_flit    merged output flit
//   out_ready       in   1           downstream ready
//   stats_clr       in   1           clear counters (macro only)
//   ring_pkt_cnt    out  STAT_WIDTH  completed ring packets (macro only)
//   local_pkt_cnt   out  STAT_WIDTH  completed local packets (macro only)
//
// BEHAVIOUR
//   - Datapath is a combinational mux: 0-cycle latency, no storage.
//   - Handshake: a flit moves when out.valid & out_ready. Only the selected
//     input sees ready=out_ready; the other input's ready is 0.
//   - FSM states: IDLE, LOCK_RING, LOCK_LOCAL. Reset -> IDLE, burst_cnt=0.
//   - IDLE selection (combinational): ring if ring_in.valid and
//     (!local_in.valid or burst_cnt<MAX_RING_BURST); else local if
//     local_in.valid; else none (out.valid=0, both readies 0).
//   - IDLE, handshake on a flit with !last -> LOCK_<selected>. Handshake
//     with last (single-flit packet) -> stay IDLE.
//   - LOCK_x: out mirrors input x (bubbles pass as out.valid=0). Other
//     input's ready=0. Handshake with last -> IDLE; re-arbitrate next cycle.
//   - burst_cnt ($clog2(MAX_RING_BURST+1) bits) updates at packet completion
//     only. Ring packet done with local_in.valid=1 -> +1, saturating at
//     MAX_RING_BURST. Ring packet done with local_in.valid=0 -> 0. Local
//     packet done -> 0.
//   - Backpressure: out_ready=0 holds the current flit; state, selection
//     and counter are frozen. No flit is dropped or duplicated.
//   - While rst=0: out.valid=0, ring_in_ready=0, local_in_ready=0. The
//     cycle after reset release starts in IDLE.
//   - Reset mid-packet drops the lock. Recovery of a partial packet is the
//     sender's responsibility.
//   - out.data and out.last are don't-care when out.valid=0.
//
// CONFIGURATION
//   DEBUG_RING_ARB_STATS_EN defined:
//     - adds stats_clr, ring_pkt_cnt and local_pkt_cnt.
//     - a counter increments on each last-flit handshake of its source and
//       saturates at all-ones.
//     - stats_clr=1 zeroes both counters and has priority over increment.
//     - reset zeroes both counters.
//   Undefined: the ports and counters do not exist; arbitration behaviour
//   is identical.
//
// TESTING
//   1. Only ring_in valid, 3-flit packet, out_ready=1 -> 3 flits appear on
//      out in the same cycles; local_in_ready=0 throughout; IDLE after.
//   2. MAX_RING_BURST=2, ring streams 1-flit packets, local holds one
//      1-flit packet each time -> grant order R,R,L,R,R,L.
//   3. Local 4-flit packet granted, ring_in goes valid after flit 2 ->
//      ring_in_ready=0 until local last accepted; ring flit out next cycle.
//   4. Ring packet mid-flight, out_ready=0 for 5 cycles, local valid ->
//      out holds the same flit; no switch; all flits delivered in order.
//   5. rst=0 for 1 cycle in LOCK_LOCAL, both valid after release -> IDLE,
//      burst_cnt=0, ring granted first, local_in_ready=0.
//   6. Macro on: 3 ring + 2 local packets -> ring_pkt_cnt=3,
//      local_pkt_cnt=2; stats_clr pulse -> 0,0. STAT_WIDTH=2 with 5
//      packets -> saturates at 3.

Source files
------------

// File: rtl/debug_ring_arbiter.sv
// ---------------------------------------------------------------------------
// debug_ring_arbiter
//
// Packet-granular 2:1 arbiter for one debug-ring output link. It merges
// ring-through traffic and local injection onto one flit stream. Once the
// first flit of a packet is accepted, the link stays locked to that source
// until the flit carrying last is accepted. Ring traffic wins in IDLE, but
// after MAX_RING_BURST consecutive ring packets a waiting local packet is
// guaranteed the next slot.
//
// The datapath is a pure combinational mux. It has zero latency and stores
// no flits. Only the arbitration state and the burst counter are registered.
//
// Optional feature macro: DEBUG_RING_ARB_STATS_EN
//   When this macro is defined, the block adds the i_stats_clr input and two
//   saturating per-source completed-packet counters.
//
// Ports
//   i_clk              clock
//   i_rst              synchronous reset, active-low
//   i_ring_in_valid    ring flit valid
//   i_ring_in_last     ring flit is last of packet
//   i_ring_in_data     ring flit payload
//   o_ring_in_ready    ring flit accepted when valid & ready
//   i_local_in_valid   local flit valid
//   i_local_in_last    local flit is last of packet
//   i_local_in_data    local flit payload
//   o_local_in_ready   local flit accepted when valid & ready
//   o_out_valid        merged flit valid
//   o_out_last         merged flit last
//   o_out_data         merged flit payload (don't-care while !o_out_valid)
//   i_out_ready        downstream ready
//   i_stats_clr        clear both packet counters        (macro only)
//   o_ring_pkt_cnt     completed ring packets, saturating  (macro only)
//   o_local_pkt_cnt    completed local packets, saturating (macro only)
// ---------------------------------------------------------------------------
module debug_ring_arbiter #(
    parameter int unsigned MAX_RING_BURST = 2,
    parameter int unsigned STAT_WIDTH     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ring_in_valid,
    input  logic                  i_ring_in_last,
    input  logic [15:0]           i_ring_in_data,
    output logic                  o_ring_in_ready,
    input  logic                  i_local_in_valid,
    input  logic                  i_local_in_last,
    input  logic [15:0]           i_local_in_data,
    output logic                  o_local_in_ready,
    output logic                  o_out_valid,
    output logic                  o_out_last,
    output logic [15:0]           o_out_data,
    input  logic                  i_out_ready
`ifdef DEBUG_RING_ARB_STATS_EN
    ,
    input  logic                  i_stats_clr,
    output logic [STAT_WIDTH-1:0] o_ring_pkt_cnt,
    output logic [STAT_WIDTH-1:0] o_local_pkt_cnt
`endif
);

    localparam int unsigned CntW = $clog2(MAX_RING_BURST + 1);
    localparam logic [CntW-1:0] MaxBurst = CntW'(MAX_RING_BURST);

    if (MAX_RING_BURST < 1 || STAT_WIDTH < 1) begin : g_param_check
        $error("debug_ring_arbiter: MAX_RING_BURST and STAT_WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLockRing,
        StLockLocal
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_burst_cnt;

    logic w_sel_ring;
    logic w_sel_local;
    logic w_fire;
    logic w_pkt_done;

    // Source selection: re-arbitrated in IDLE and pinned while a packet is
    // locked. Both selects drop while reset is asserted, so the link is
    // silent during reset.
    always_comb begin
        w_sel_ring  = 1'b0;
        w_sel_local = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_ring_in_valid && (!i_local_in_valid || (r_burst_cnt < MaxBurst))) begin
                    w_sel_ring = 1'b1;
                end else if (i_local_in_valid) begin
                    w_sel_local = 1'b1;
                end
            end
            StLockRing:  w_sel_ring  = 1'b1;
            StLockLocal: w_sel_local = 1'b1;
            default: begin
                w_sel_ring  = 1'b0;
                w_sel_local = 1'b0;
            end
        endcase
        if (!i_rst) begin
            w_sel_ring  = 1'b0;
            w_sel_local = 1'b0;
        end
    end

    // Zero-latency output mux. In a locked state, bubbles on the locked
    // input pass straight through as o_out_valid=0.
    always_comb begin
        o_out_valid = 1'b0;
        o_out_last  = 1'b0;
        o_out_data  = '0;
        if (w_sel_ring) begin
            o_out_valid = i_ring_in_valid;
            o_out_last  = i_ring_in_last;
            o_out_data  = i_ring_in_data;
        end else if (w_sel_local) begin
            o_out_valid = i_local_in_valid;
            o_out_last  = i_local_in_last;
            o_out_data  = i_local_in_data;
        end
    end

    assign o_ring_in_ready  = w_sel_ring & i_out_ready;
    assign o_local_in_ready = w_sel_local & i_out_ready;

    assign w_fire     = o_out_valid & i_out_ready;
    assign w_pkt_done = w_fire & o_out_last;

    // Arbitration FSM. Nothing moves without a handshake, so backpressure
    // freezes the state and the burst counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_burst_cnt <= '0;
        end else if (w_fire) begin
            if (o_out_last) begin
                r_state <= StIdle;
                // The burst count only grows while local is actually waiting.
                // Any other packet completion restarts the ring's run.
                if (w_sel_ring && i_local_in_valid) begin
                    if (r_burst_cnt != MaxBurst) begin
                        r_burst_cnt <= r_burst_cnt + CntW'(1);
                    end
                end else begin
                    r_burst_cnt <= '0;
                end
            end else begin
                r_state <= w_sel_ring ? StLockRing : StLockLocal;
            end
        end
    end

`ifdef DEBUG_RING_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_ring_pkt_cnt;
    logic [STAT_WIDTH-1:0] r_local_pkt_cnt;

    // Clearing the counters takes priority over counting a packet that
    // completes in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_stats_clr) begin
            r_ring_pkt_cnt  <= '0;
            r_local_pkt_cnt <= '0;
        end else if (w_pkt_done) begin
            if (w_sel_ring && (r_ring_pkt_cnt != '1)) begin
                r_ring_pkt_cnt <= r_ring_pkt_cnt + STAT_WIDTH'(1);
            end
            if (w_sel_local && (r_local_pkt_cnt != '1)) begin
                r_local_pkt_cnt <= r_local_pkt_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign o_ring_pkt_cnt  = r_ring_pkt_cnt;
    assign o_local_pkt_cnt = r_local_pkt_cnt;
`endif

endmodule

// File: tb/tb_debug_ring_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debug_ring_arbiter
//
// Scoreboard bench for debug_ring_arbiter (MAX_RING_BURST=2). Two source
// queues feed the ring and local inputs. Each test pushes its flits together
// with the expected output order into sb_q. A monitor pops sb_q on every
// output handshake and compares. Directed per-cycle checks cover readiness,
// stalls and reset. Define DEBUG_RING_ARB_STATS_EN to also exercise the
// packet counters; they are built with STAT_WIDTH=2 so saturation is
// reachable.
// ---------------------------------------------------------------------------
module tb_debug_ring_arbiter;

    localparam int unsigned StatW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ring_valid, ring_last, ring_ready;
    logic [15:0] ring_data;
    logic        local_valid, local_last, local_ready;
    logic [15:0] local_data;
    logic        out_valid, out_last, out_ready;
    logic [15:0] out_data;
`ifdef DEBUG_RING_ARB_STATS_EN
    logic             stats_clr;
    logic [StatW-1:0] ring_cnt, local_cnt;
`endif

    always #5 clk = ~clk;

    debug_ring_arbiter #(
        .MAX_RING_BURST (2),
        .STAT_WIDTH     (StatW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ring_in_valid  (ring_valid),
        .i_ring_in_last   (ring_last),
        .i_ring_in_data   (ring_data),
        .o_ring_in_ready  (ring_ready),
        .i_local_in_valid (local_valid),
        .i_local_in_last  (local_last),
        .i_local_in_data  (local_data),
        .o_local_in_ready (local_ready),
        .o_out_valid      (out_valid),
        .o_out_last       (out_last),
        .o_out_data       (out_data),
        .i_out_ready      (out_ready)
`ifdef DEBUG_RING_ARB_STATS_EN
        ,
        .i_stats_clr      (stats_clr),
        .o_ring_pkt_cnt   (ring_cnt),
        .o_local_pkt_cnt  (local_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Flits are stored as {last, data}.
    logic [16:0] ring_q[$];
    logic [16:0] local_q[$];
    logic [16:0] sb_q[$];
    bit          ring_fire;
    bit          local_fire;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        ring_valid  = (ring_q.size() != 0);
        local_valid = (local_q.size() != 0);
        ring_last   = 1'b0;
        ring_data   = 16'h0;
        local_last  = 1'b0;
        local_data  = 16'h0;
        if (ring_valid) {ring_last, ring_data} = ring_q[0];
        if (local_valid) {local_last, local_data} = local_q[0];
    endtask

    task automatic push_ring(input logic [15:0] d, input logic l);
        ring_q.push_back({l, d});
    endtask

    task automatic push_local(input logic [15:0] d, input logic l);
        local_q.push_back({l, d});
    endtask

    task automatic expect_flit(input logic [15:0] d, input logic l);
        sb_q.push_back({l, d});
    endtask

    // Wait until every queued flit has been delivered; ends at posedge+2.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || ring_q.size() != 0 || local_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s_drain got=%0d_pending exp=0_pending", name, sb_q.size());
            sb_q.delete();
            ring_q.delete();
            local_q.delete();
        end
        @(posedge clk);
        #2;
        drive_inputs();
    endtask

    // Handshakes sampled mid-cycle, when the inputs are stable.
    always @(negedge clk) begin
        ring_fire  = ring_valid && ring_ready;
        local_fire = local_valid && local_ready;
    end

    // Source driver: retire accepted flits and present the next ones.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ring_fire && ring_q.size() != 0) ring_q.delete(0);
            if (local_fire && local_q.size() != 0) local_q.delete(0);
            drive_inputs();
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%0h exp=none", {out_last, out_data});
            end else begin
                if ({out_last, out_data} !== sb_q[0]) begin
                    failures++;
                    $display("FAIL sb_flit got=%0h exp=%0h at %0t", {out_last, out_data},
                             sb_q[0], $time);
                end
                sb_q.delete(0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
`ifdef DEBUG_RING_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_ring_ready", ring_ready, 0);
        check("rst_local_ready", local_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
`ifdef DEBUG_RING_ARB_STATS_EN
        check("rst_ring_cnt", ring_cnt, 0);
        check("rst_local_cnt", local_cnt, 0);
`endif
        @(posedge clk);
        #2;

        // 1: lone 3-flit ring packet passes with zero latency.
        for (int k = 0; k < 3; k++) begin
            push_ring(16'h1000 + 16'(k), k == 2);
            expect_flit(16'h1000 + 16'(k), k == 2);
        end
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_out_valid", out_valid, 1);
            check("t1_out_data", out_data, 32'h1000 + k);
            check("t1_ring_ready", ring_ready, 1);
            check("t1_local_ready", local_ready, 0);
        end
        @(negedge clk);
        check("t1_idle_after", out_valid, 0);
        wait_drain("t1");

        // 2: burst limit gives R,R,L,R,R,L.
        for (int k = 0; k < 4; k++) push_ring(16'h1100 + 16'(k), 1'b1);
        push_local(16'h2100, 1'b1);
        push_local(16'h2101, 1'b1);
        expect_flit(16'h1100, 1'b1);
        expect_flit(16'h1101, 1'b1);
        expect_flit(16'h2100, 1'b1);
        expect_flit(16'h1102, 1'b1);
        expect_flit(16'h1103, 1'b1);
        expect_flit(16'h2101, 1'b1);
        drive_inputs();
        wait_drain("t2");

        // 3: local 4-flit packet keeps the lock against a late ring flit.
        for (int k = 0; k < 4; k++) begin
            push_local(16'h2200 + 16'(k), k == 3);
            expect_flit(16'h2200 + 16'(k), k == 3);
        end
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        push_ring(16'h1200, 1'b1);
        expect_flit(16'h1200, 1'b1);
        drive_inputs();
        @(negedge clk);
        check("t3_ring_ready_f2", ring_ready, 0);
        check("t3_data_f2", out_data, 32'h2202);
        @(negedge clk);
        check("t3_ring_ready_f3", ring_ready, 0);
        check("t3_data_f3", out_data, 32'h2203);
        @(negedge clk);
        check("t3_ring_ready_after", ring_ready, 1);
        check("t3_data_after", out_data, 32'h1200);
        wait_drain("t3");

        // 4: 5-cycle stall mid ring packet with local waiting.
        for (int k = 0; k < 3; k++) begin
            push_ring(16'h1300 + 16'(k), k == 2);
            expect_flit(16'h1300 + 16'(k), k == 2);
        end
        push_local(16'h2300, 1'b1);
        expect_flit(16'h2300, 1'b1);
        drive_inputs();
        @(negedge clk);
        check("t4_first", out_data, 32'h1300);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_data", out_data, 32'h1301);
            check("t4_stall_local_ready", local_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_resume_data", out_data, 32'h1301);
        check("t4_resume_ring_ready", ring_ready, 1);
        wait_drain("t4");

        // 5: reset inside LOCK_LOCAL while the burst count is at its limit.
        push_ring(16'h1400, 1'b1);
        push_ring(16'h1401, 1'b1);
        for (int k = 0; k < 3; k++) push_local(16'h2400 + 16'(k), k == 2);
        expect_flit(16'h1400, 1'b1);
        expect_flit(16'h1401, 1'b1);
        expect_flit(16'h2400, 1'b0);
        drive_inputs();
        repeat (3) @(negedge clk);
        check("t5_local_grant", out_data, 32'h2400);
        check("t5_local_ready", local_ready, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_ring(16'h1402, 1'b1);
        push_ring(16'h1403, 1'b1);
        expect_flit(16'h1402, 1'b1);
        expect_flit(16'h1403, 1'b1);
        expect_flit(16'h2401, 1'b0);
        expect_flit(16'h2402, 1'b1);
        drive_inputs();
        @(negedge clk);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_ring_ready", ring_ready, 0);
        check("t5_rst_local_ready", local_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t5_ring_first", ring_ready, 1);
        check("t5_local_blocked", local_ready, 0);
        check("t5_data", out_data, 32'h1402);
        wait_drain("t5");

`ifdef DEBUG_RING_ARB_STATS_EN
        // 6: counters restarted by the reset in test 5.
        @(negedge clk);
        check("t6_ring_after_rst", ring_cnt, 2);
        check("t6_local_after_rst", local_cnt, 1);
        @(posedge clk);
        #2;
        stats_clr = 1'b1;
        @(posedge clk);
        #2;
        stats_clr = 1'b0;
        @(negedge clk);
        check("t6_clr_ring", ring_cnt, 0);
        check("t6_clr_local", local_cnt, 0);
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) push_ring(16'h1500 + 16'(k), 1'b1);
        push_local(16'h2500, 1'b1);
        push_local(16'h2501, 1'b1);
        expect_flit(16'h1500, 1'b1);
        expect_flit(16'h1501, 1'b1);
        expect_flit(16'h2500, 1'b1);
        expect_flit(16'h1502, 1'b1);
        expect_flit(16'h2501, 1'b1);
        drive_inputs();
        wait_drain("t6a");
        @(negedge clk);
        check("t6_ring_cnt", ring_cnt, 3);
        check("t6_local_cnt", local_cnt, 2);
        @(posedge clk);
        #2;
        stats_clr = 1'b1;
        @(posedge clk);
        #2;
        stats_clr = 1'b0;
        @(negedge clk);
        check("t6_clr2_ring", ring_cnt, 0);
        check("t6_clr2_local", local_cnt, 0);
        @(posedge clk);
        #2;
        for (int k = 0; k < 5; k++) begin
            push_ring(16'h1600 + 16'(k), 1'b1);
            expect_flit(16'h1600 + 16'(k), 1'b1);
        end
        drive_inputs();
        wait_drain("t6b");
        @(negedge clk);
        check("t6_ring_sat", ring_cnt, 3);
        check("t6_local_zero", local_cnt, 0);
`endif

        repeat (2) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
